lifo_stream_drain: RTL and testbench
====================================

// Module: lifo_stream_drain
// PURPOSE
//  Downstream stage of the synchronous 4-bit LIFO. Pops the LIFO whenever it is non-empty and
//  re-presents the popped words as a valid/ready stream through a 2-entry skid buffer.
//  Absorbs the LIFO's 1-cycle read latency so the consumer can stall on any cycle without
//  losing or duplicating a word. Output order is pop order, i.e. last-written-first.
// PARAMETERS
//  DATA_WIDTH  4  word width; must equal the LIFO data width
// PORTS
//  clk         in   1           single clock, all state on posedge
//  rst         in   1           synchronous reset, active-high
//  lifo_empty  in   1           LIFO empty flag (registered, updates on the pop edge)
//  lifo_dout   in   DATA_WIDTH  LIFO dataOut; valid the cycle after a sampled pop
//  lifo_rd_en  out  1           pop request to the LIFO (combinational from state + lifo_empty)
//  flush       in   1           discard buffered and in-flight words
//  m_valid     out  1           stream word available
//  m_ready     in   1           consumer accepts; handshake = m_valid & m_ready
//  m_data      out  DATA_WIDTH  stream word (head of skid buffer)
//  pop_count   out  16          accepted-word count; present only with LIFO_DRAIN_CNT_EN
// BEHAVIOUR
//  - LIFO contract: rd_en & !empty sampled at edge N -> word on lifo_dout during cycle N+1.
//  - State: skid FIFO of 2 entries (head/tail ptr, occupancy cnt 0..2) and inflight flag (1 bit).
//  - inflight <= lifo_rd_en & !lifo_empty at each edge; at the next edge lifo_dout is written to the tail.
//  - lifo_rd_en = !lifo_empty & !flush & !rst & (cnt + inflight - (m_valid&m_ready)) < 2.
//    A word leaving this cycle frees a slot, so a continuous consumer gets 1 word/cycle.
//  - m_valid = (cnt != 0); m_data = entry[head]; m_data holds stable while m_valid & !m_ready.
//  - Same-edge write (inflight) and read (handshake): cnt unchanged, both ptrs advance.
//  - Write into a buffer of 2 entries that is not draining is impossible by construction.
//    The bench checks this as an assertion.
//  - Ptr wrap: 1-bit ptrs, 1 -> 0.
//  - flush=1 at an edge: cnt <= 0, ptrs <= 0, inflight <= 0. The arriving in-flight word is dropped.
//    lifo_rd_en=0 during the flush cycle. The handshake in the flush cycle still counts (m_valid was 1).
//  - LIFO empty with nothing buffered: m_valid=0 and lifo_rd_en=0, with no spurious pops.
//  - Reset (any cycle, incl. mid-drain): cnt=0, ptrs=0, inflight=0, m_valid=0, lifo_rd_en=0,
//    m_data=0 (entries cleared), pop_count=0. An in-flight word returning after reset is ignored.
//  - lifo_rd_en never asserts while rst=1, so a LIFO under common reset sees no pop.
// CONFIGURATION
//  LIFO_DRAIN_CNT_EN defined:
//    pop_count port exists, +1 per handshake, saturates at 16'hFFFF.
//    Cleared only by rst; flush does not clear it.
//  LIFO_DRAIN_CNT_EN undefined:
//    pop_count port and counter are absent. All other behaviour is identical.
// TESTING
//  1 Reset: rst=1 for 3 clks with lifo_empty=0 -> lifo_rd_en=0, m_valid=0, m_data=0 all 3 cycles.
//  2 Stream: LIFO holds 0,3,7,A (pushed in that order), m_ready=1.
//    -> m_data A,7,3,0 on consecutive cycles, first word 2 cycles after rst falls, then m_valid=0.
//  3 Stall: same load, m_ready=0 for 6 clks -> exactly 2 pops, m_data=A held stable, cnt=2.
//    Release m_ready -> A,7,3,0 with no loss or duplication.
//  4 Alternating m_ready (1,0,1,0...) over 4 words -> order A,7,3,0 preserved.
//    Skid-overflow assertion never fires.
//  5 flush asserted the cycle after a pop with cnt=1 -> m_valid=0 next cycle, in-flight word dropped.
//    The remaining LIFO words then drain in order.
//  6 LIFO_DRAIN_CNT_EN: 4 accepted words then flush -> pop_count=4.
//    Force count to 16'hFFFE plus 3 handshakes -> 16'hFFFF.

Source files
------------

// File: rtl/lifo_stream_drain_if.sv
// LIFO-drain bus: LIFO pop side, flush, and the outgoing valid/ready stream.
// pop_count exists only when LIFO_DRAIN_CNT_EN is defined.
interface lifo_stream_drain_if #(
  parameter int DATA_WIDTH = 4
) ();
  logic                  lifo_empty;
  logic [DATA_WIDTH-1:0] lifo_dout;
  logic                  lifo_rd_en;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
`ifdef LIFO_DRAIN_CNT_EN
  logic [15:0]           pop_count;
`endif

  modport master (
`ifdef LIFO_DRAIN_CNT_EN
    output pop_count,
`endif
    input  lifo_empty, lifo_dout, flush, m_ready,
    output lifo_rd_en, m_valid, m_data
  );

  modport slave (
`ifdef LIFO_DRAIN_CNT_EN
    input  pop_count,
`endif
    output lifo_empty, lifo_dout, flush, m_ready,
    input  lifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/lifo_stream_drain.sv
// Pops a 1-cycle-latency LIFO and re-presents words as a valid/ready stream via a 2-entry skid.
// Optional accepted-word counter enabled by LIFO_DRAIN_CNT_EN.
module lifo_stream_drain #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  lifo_stream_drain_if.master  bus
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic [1:0]            r_cnt;
  logic                  r_head;
  logic                  r_tail;
  logic                  r_inflight;

  logic                  w_valid;
  logic                  w_hs;
  logic                  w_rd_en;
  logic [2:0]            w_occ;

  assign w_valid = (r_cnt != 2'd0);
  assign w_hs    = w_valid & bus.m_ready;

  // Occupancy once this cycle's in-flight word lands and any accepted word leaves.
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_hs};
  assign w_rd_en = !bus.lifo_empty & !bus.flush & !rst & (w_occ < 3'd2);

  assign bus.lifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = r_mem[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 2'd0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_inflight <= 1'b0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
    end else if (bus.flush) begin
      r_cnt      <= 2'd0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (r_inflight) begin
        r_mem[r_tail] <= bus.lifo_dout;
        r_tail        <= ~r_tail;
      end
      if (w_hs) begin
        r_head <= ~r_head;
      end
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_hs};
    end
  end

`ifdef LIFO_DRAIN_CNT_EN
  logic [15:0] r_pop_count;

  // Saturating; flush leaves it alone so it tracks total delivered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pop_count <= 16'd0;
    end else if (w_hs && (r_pop_count != 16'hFFFF)) begin
      r_pop_count <= r_pop_count + 16'd1;
    end
  end

  assign bus.pop_count = r_pop_count;
`endif

endmodule

// File: tb/tb_lifo_stream_drain.sv
// Bench for lifo_stream_drain: behavioural LIFO + queue-based skid model, directed and random stimulus.
module tb_lifo_stream_drain;
  logic clk;
  logic rst;

  lifo_stream_drain_if #(.DATA_WIDTH(4)) bus ();

  lifo_stream_drain #(.DATA_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad   = 0;
  int         cyc_n   = 0;
  int         n_pop   = 0;
  int         cnt_m   = 0;
  logic [3:0] stack  [$];
  logic [3:0] exp_q  [$];
  logic [3:0] got    [$];
  int         got_t  [$];
  logic       pipe_v = 1'b0;
  logic [3:0] pipe_w = 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic load4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    stack.delete();
    stack.push_back(a);
    stack.push_back(b);
    stack.push_back(c);
    stack.push_back(d);
    bus.lifo_empty = 1'b0;
  endtask

  // Expected words packed high nibble first.
  task automatic chk_seq(input string tag, input logic [15:0] words, input int n);
    chk({tag, "_n"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk({tag, "_w"}, got[i], words[15-4*i -: 4]);
  endtask

  // One clock: drive inputs at negedge, check against the model, then advance LIFO and model.
  task automatic step(input logic r, input logic rdy, input logic fl);
    logic       hs;
    logic       popped;
    logic       exp_rd;
    int         occ;
    logic [3:0] w;
    @(negedge clk);
    rst         = r;
    bus.m_ready = rdy;
    bus.flush   = fl;
    #1;
    chk("m_valid", bus.m_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("m_data", bus.m_data, exp_q[0]);
    hs     = (exp_q.size() != 0) && rdy;
    occ    = exp_q.size() + int'(pipe_v) - int'(hs);
    exp_rd = !bus.lifo_empty && !fl && !r && (occ < 2);
    chk("rd_en", bus.lifo_rd_en, exp_rd);
`ifdef LIFO_DRAIN_CNT_EN
    chk("pop_count", bus.pop_count, cnt_m);
`endif
    popped = bus.lifo_rd_en && !bus.lifo_empty;
    if (bus.m_valid && rdy) begin
      got.push_back(bus.m_data);
      got_t.push_back(cyc_n);
    end
    if (hs) void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    w = 4'h0;
    if (popped) begin
      w = stack.pop_back();
      n_pop++;
      bus.lifo_dout  = w;
      bus.lifo_empty = (stack.size() == 0);
    end
    if (r) begin
      exp_q.delete();
      pipe_v = 1'b0;
      cnt_m  = 0;
    end else begin
      if (hs && cnt_m != 32'hFFFF) cnt_m++;
      if (fl) begin
        exp_q.delete();
        pipe_v = 1'b0;
      end else begin
        if (pipe_v) exp_q.push_back(pipe_w);
        pipe_v = popped;
        pipe_w = w;
      end
    end
    chk("skid_ovf", exp_q.size() <= 2, 1);
    cyc_n++;
  endtask

  task automatic restart();
    step(1'b1, 1'b0, 1'b0);
    got.delete();
    got_t.delete();
    n_pop = 0;
    cyc_n = 0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.m_ready    = 1'b0;
    bus.lifo_empty = 1'b1;
    bus.lifo_dout  = 4'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with a non-empty LIFO: no pops, no output.
    load4(4'h0, 4'h3, 4'h7, 4'hA);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("rst_rd_en", bus.lifo_rd_en, 0);
      chk("rst_valid", bus.m_valid, 0);
      chk("rst_data", bus.m_data, 0);
    end
    chk("rst_no_pop", stack.size(), 4);

    // Continuous drain.
    load4(4'h0, 4'h3, 4'h7, 4'hA);
    restart();
    repeat (8) step(1'b0, 1'b1, 1'b0);
    chk_seq("stream", 16'hA730, 4);
    for (int i = 0; i < got_t.size(); i++) chk("stream_t", got_t[i], i + 2);
`ifdef LIFO_DRAIN_CNT_EN
    step(1'b0, 1'b1, 1'b1);
    chk("cnt_after_flush", bus.pop_count, 4);
`endif

    // Stall then release.
    load4(4'h0, 4'h3, 4'h7, 4'hA);
    restart();
    repeat (6) step(1'b0, 1'b0, 1'b0);
    chk("stall_pops", n_pop, 2);
    chk("stall_hold", bus.m_data, 4'hA);
    repeat (8) step(1'b0, 1'b1, 1'b0);
    chk_seq("stall", 16'hA730, 4);

    // Alternating ready.
    load4(4'h0, 4'h3, 4'h7, 4'hA);
    restart();
    for (int i = 0; i < 14; i++) step(1'b0, (i % 2) == 0, 1'b0);
    chk_seq("alt", 16'hA730, 4);

    // Flush with one buffered word and one in flight.
    load4(4'h0, 4'h3, 4'h7, 4'hA);
    restart();
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("flush_valid", bus.m_valid, 0);
    got.delete();
    repeat (6) step(1'b0, 1'b1, 1'b0);
    chk_seq("flush", 16'h3000, 2);

`ifdef LIFO_DRAIN_CNT_EN
    // Counter saturation.
    load4(4'h0, 4'h3, 4'h7, 4'hA);
    restart();
    step(1'b0, 1'b0, 1'b0);
    force dut.r_pop_count = 16'hFFFE;
    #1;
    release dut.r_pop_count;
    cnt_m = 32'hFFFE;
    repeat (8) step(1'b0, 1'b1, 1'b0);
    chk("cnt_sat", bus.pop_count, 16'hFFFF);
`endif

    // Random pushes, ready, flush and reset.
    stack.delete();
    bus.lifo_empty = 1'b1;
    restart();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0 && stack.size() < 8) begin
        stack.push_back(4'($urandom_range(0, 15)));
        bus.lifo_empty = 1'b0;
      end
      step($urandom_range(0, 99) < 2, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 5);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
